// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU, one transaction in flight at a time.
// Latency: accept->mem_en 1 cycle, mem_rsp->rsp_valid 1 cycle; req ready only in IDLE, mem_en held until mem_ready.
module mem_port_arbiter #(
  parameter bit LSU_PRIO = 1'b0,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rsp_data,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_req_wr,
  input  logic [31:0] lsu_req_addr,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wstrb,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_data,
  output logic        lsu_rsp_err,
  output logic        mem_en,
  input  logic        mem_ready,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam bit               WDOG_EN     = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_lsu;
  logic             owner_lsu;
  logic             op_wr;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  logic [3:0]       op_wstrb;
  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_pend;
  logic             rsp_lsu;
  logic [31:0]      rsp_data;
  logic             grant_ifu;
  logic             grant_lsu;
  logic             timeout;

  // The cycle carrying a registered response is still closed to new requests.
  always_comb begin
    state_next = state;
    grant_ifu  = 1'b0;
    grant_lsu  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && !rsp_pend) begin
          if (lsu_req_valid && (!ifu_req_valid || LSU_PRIO || !last_lsu)) begin
            grant_lsu = 1'b1;
          end else if (ifu_req_valid) begin
            grant_ifu = 1'b1;
          end
        end
        if (grant_ifu || grant_lsu) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_next = IDLE;
        end else if (rst_n && WDOG_EN && (wait_cnt == TIMEOUT_CNT)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_lsu  <= 1'b1;
      owner_lsu <= 1'b0;
      op_wr     <= 1'b0;
      op_addr   <= 32'h0;
      op_wdata  <= 32'h0;
      op_wstrb  <= 4'h0;
      wait_cnt  <= '0;
      rsp_pend  <= 1'b0;
      rsp_lsu   <= 1'b0;
      rsp_data  <= 32'h0;
    end else begin
      state    <= state_next;
      rsp_pend <= 1'b0;
      if (grant_ifu || grant_lsu) begin
        owner_lsu <= grant_lsu;
        last_lsu  <= grant_lsu;
        op_wr     <= grant_lsu && lsu_req_wr;
        op_addr   <= grant_lsu ? lsu_req_addr : ifu_req_addr;
        op_wdata  <= grant_lsu ? lsu_req_wdata : 32'h0;
        op_wstrb  <= (grant_lsu && lsu_req_wr) ? lsu_req_wstrb : 4'h0;
      end
      if (state == ISSUE && mem_ready) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CNT_ONE;
      end
      if (state == WAIT && mem_rsp_valid) begin
        rsp_pend <= 1'b1;
        rsp_lsu  <= owner_lsu;
        rsp_data <= mem_rdata;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  assign mem_en    = (state == ISSUE);
  assign mem_wr    = op_wr;
  assign mem_addr  = op_addr;
  assign mem_wdata = op_wdata;
  assign mem_wstrb = op_wstrb;

  // Timeout responses are combinational in the expiring WAIT cycle and carry zero data.
  assign ifu_rsp_valid = (rsp_pend && !rsp_lsu) || (timeout && !owner_lsu);
  assign ifu_rsp_err   = timeout && !owner_lsu;
  assign ifu_rsp_data  = (rsp_pend && !rsp_lsu) ? rsp_data : 32'h0;
  assign lsu_rsp_valid = (rsp_pend && rsp_lsu) || (timeout && owner_lsu);
  assign lsu_rsp_err   = timeout && owner_lsu;
  assign lsu_rsp_data  = (rsp_pend && rsp_lsu) ? rsp_data : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level timing model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, lsu_req_valid, lsu_req_wr, mem_ready, mem_rsp_valid;
  logic [31:0] ifu_req_addr, lsu_req_addr, lsu_req_wdata, mem_rdata;
  logic [3:0]  lsu_req_wstrb;

  logic        ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] ifu_rsp_data, lsu_rsp_data, mem_addr, mem_wdata;
  logic        mem_en, mem_wr;
  logic [3:0]  mem_wstrb;

  logic        p_ifu_req_ready, p_ifu_rsp_valid, p_ifu_rsp_err, p_lsu_req_ready, p_lsu_rsp_valid, p_lsu_rsp_err;
  logic [31:0] p_ifu_rsp_data, p_lsu_rsp_data, p_mem_addr, p_mem_wdata;
  logic        p_mem_en, p_mem_wr;
  logic [3:0]  p_mem_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LSU_PRIO(1'b0), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wr(lsu_req_wr),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_en(mem_en), .mem_ready(mem_ready), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.LSU_PRIO(1'b1), .TIMEOUT(TO), .CNT_W(8)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(p_ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(p_ifu_rsp_valid), .ifu_rsp_data(p_ifu_rsp_data), .ifu_rsp_err(p_ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(p_lsu_req_ready), .lsu_req_wr(lsu_req_wr),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(p_lsu_rsp_valid), .lsu_rsp_data(p_lsu_rsp_data), .lsu_rsp_err(p_lsu_rsp_err),
    .mem_en(p_mem_en), .mem_ready(mem_ready), .mem_wr(p_mem_wr), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_wstrb(p_mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_req_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_req_wr = 1'b0; lsu_req_addr = 32'h0;
    lsu_req_wdata = 32'h0; lsu_req_wstrb = 4'h0;
    mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    next();
    rst_n = 1'b0;
    idle_inputs();
    next();
    rst_n = 1'b1;
  endtask

  // Random-phase model state: one transaction at a time, timed by arithmetic on cycle numbers.
  int          c, free_at, ph, rdy_at, acc, rsp_at, exp_at;
  bit          m_last_lsu, ip, lp, e_i, e_l, exp_err, t_lsu, t_wr, l_wr;
  logic [31:0] i_addr, l_addr, l_wdata, t_addr, t_wdata, exp_data, rd_val;
  logic [3:0]  l_wstrb, t_wstrb;

  initial begin
    // Reset with every input asserted: nothing may leak out.
    rst_n = 1'b0;
    idle_inputs();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_ready = 1'b1; mem_rsp_valid = 1'b1;
    next();
    next(); #3;
    chk("rst_ifu_rdy", ifu_req_ready, 1'b0);
    chk("rst_lsu_rdy", lsu_req_ready, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rsp_vld", {ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}, 4'h0);
    chk("rst_p_rdy", {p_ifu_req_ready, p_lsu_req_ready, p_mem_en}, 3'b000);
    rst_n = 1'b1;
    idle_inputs();

    // IFU fetch, cycle 0 accept, cycle 3 response.
    next(); ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; mem_ready = 1'b1; #3;
    chk("t1_ifu_rdy", ifu_req_ready, 1'b1);
    chk("t1_lsu_rdy", lsu_req_ready, 1'b0);
    next(); ifu_req_valid = 1'b0; ifu_req_addr = $urandom; #3;
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    chk("t1_mem_rd", {mem_wr, mem_wstrb}, 5'b0);
    next(); mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0413; #3;
    chk("t1_c2_rsp", {ifu_rsp_valid, lsu_rsp_valid, mem_en}, 3'b000);
    next(); mem_rsp_valid = 1'b0; mem_rdata = $urandom; #3;
    chk("t1_c3_vld", ifu_rsp_valid, 1'b1);
    chk("t1_c3_data", ifu_rsp_data, 32'h0000_0413);
    chk("t1_c3_err", ifu_rsp_err, 1'b0);
    chk("t1_c3_lsu", lsu_rsp_valid, 1'b0);
    next(); #3;
    chk("t1_c4_vld", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);

    // Contention with an always-ready memory: round-robin vs LSU priority.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      next();
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h100; lsu_req_valid = 1'b1; lsu_req_addr = 32'h200;
      lsu_req_wr = 1'b0; mem_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h1000 + i;
      #3;
      chk("t3_ifu_rdy", ifu_req_ready, (i % 2 == 0));
      chk("t3_lsu_rdy", lsu_req_ready, (i % 2 == 1));
      chk("t3_prio_rdy", {p_ifu_req_ready, p_lsu_req_ready}, 2'b01);
      next(); #3;
      chk("t3_iss_rdy", {ifu_req_ready, lsu_req_ready}, 2'b00);
      chk("t3_iss_addr", mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      next(); #3;
      chk("t3_wait_en", mem_en, 1'b0);
      next(); #3;
      chk("t3_rsp_vld", {ifu_rsp_valid, lsu_rsp_valid}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("t3_rsp_data", (i % 2 == 0) ? ifu_rsp_data : lsu_rsp_data, 32'h1000 + i);
      chk("t3_rsp_rdy", {ifu_req_ready, lsu_req_ready}, 2'b00);
      chk("t3_prio_rsp", p_lsu_rsp_valid, 1'b1);
    end

    // LSU store held in ISSUE for 10 cycles while IFU waits.
    next();
    idle_inputs();
    lsu_req_valid = 1'b1; lsu_req_wr = 1'b1; lsu_req_addr = 32'h8000_1000;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'b0011;
    #3;
    chk("t2_lsu_rdy", lsu_req_ready, 1'b1);
    chk("t2_ifu_rdy", ifu_req_ready, 1'b0);
    for (int j = 0; j < 10; j++) begin
      next();
      lsu_req_valid = 1'b0; lsu_req_wr = $urandom; lsu_req_addr = $urandom;
      lsu_req_wdata = $urandom; lsu_req_wstrb = $urandom;
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040; mem_rsp_valid = $urandom;
      #3;
      chk("t5_mem_en", mem_en, 1'b1);
      chk("t5_mem_wr", mem_wr, 1'b1);
      chk("t5_mem_addr", mem_addr, 32'h8000_1000);
      chk("t5_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t5_mem_wstrb", mem_wstrb, 4'b0011);
      chk("t5_rdy", {ifu_req_ready, lsu_req_ready, lsu_rsp_valid}, 3'b000);
    end
    next(); mem_ready = 1'b1; mem_rsp_valid = 1'b0; #3;
    chk("t5_go_en", mem_en, 1'b1);
    next(); mem_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = $urandom; #3;
    chk("t2_wait", {mem_en, lsu_rsp_valid}, 2'b00);
    next(); mem_rsp_valid = 1'b0; #3;
    chk("t2_rsp", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid}, 3'b100);
    chk("t2_rsp_rdy", ifu_req_ready, 1'b0);

    // IFU timeout, then a load with stale responses around it.
    next(); #3;
    chk("t4_ifu_rdy", {ifu_req_ready, lsu_req_ready}, 2'b10);
    next(); ifu_req_valid = 1'b0; mem_ready = 1'b1; #3;
    chk("t4_iss", {mem_en, mem_wstrb}, 5'b10000);
    chk("t4_iss_addr", mem_addr, 32'h8000_0040);
    for (int w = 1; w <= TO + 1; w++) begin
      next(); mem_ready = $urandom; #3;
      chk("t4_wait_en", mem_en, 1'b0);
      if (w <= TO) begin
        chk("t4_early", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
      end else begin
        chk("t4_to_vld", {ifu_rsp_valid, lsu_rsp_valid}, 2'b10);
        chk("t4_to_err", ifu_rsp_err, 1'b1);
        chk("t4_to_data", ifu_rsp_data, 32'h0);
      end
    end
    next();
    lsu_req_valid = 1'b1; lsu_req_wr = 1'b0; lsu_req_addr = 32'h8000_2000; lsu_req_wstrb = 4'hF;
    mem_ready = 1'b0; mem_rsp_valid = 1'b1;
    #3;
    chk("t4_next_rdy", lsu_req_ready, 1'b1);
    chk("t4_stale0", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    next(); lsu_req_valid = 1'b0; mem_ready = 1'b1; mem_rsp_valid = 1'b1; #3;
    chk("t4_ld_iss", {mem_en, mem_wr, mem_wstrb}, 6'b100000);
    chk("t4_stale1", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    next(); mem_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D; #3;
    chk("t4_stale2", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    next(); mem_rsp_valid = 1'b0; #3;
    chk("t4_ld_rsp", {lsu_rsp_valid, lsu_rsp_err}, 2'b10);
    chk("t4_ld_data", lsu_rsp_data, 32'hCAFE_F00D);

    // Reset while waiting for the response.
    next(); lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000; #3;
    chk("t6_acc", lsu_req_ready, 1'b1);
    next(); lsu_req_valid = 1'b0; mem_ready = 1'b1; #3;
    chk("t6_iss", mem_en, 1'b1);
    next(); mem_ready = 1'b0; rst_n = 1'b0; mem_rsp_valid = 1'b1; #3;
    chk("t6_rst_rdy", {ifu_req_ready, lsu_req_ready}, 2'b00);
    next(); rst_n = 1'b1; mem_rsp_valid = 1'b1; #3;
    chk("t6_no_rsp", {ifu_rsp_valid, lsu_rsp_valid, mem_en}, 3'b000);
    next(); mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; #3;
    chk("t6_no_rsp2", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    chk("t6_ifu_wins", {ifu_req_ready, lsu_req_ready}, 2'b10);

    // Randomized traffic against the model.
    do_reset();
    free_at = 0; ph = 0; m_last_lsu = 1'b1; ip = 1'b0; lp = 1'b0;
    rsp_at = -1; exp_at = -1;
    for (c = 0; c < 1500; c++) begin
      next();
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1'b1; i_addr = $urandom;
      end else if (ip && $urandom_range(0, 9) == 0) begin
        ip = 1'b0;
      end
      if (!lp && $urandom_range(0, 2) == 0) begin
        lp = 1'b1; l_addr = $urandom; l_wdata = $urandom;
        l_wr = $urandom_range(0, 1); l_wstrb = $urandom_range(1, 15);
      end else if (lp && $urandom_range(0, 9) == 0) begin
        lp = 1'b0;
      end
      ifu_req_valid = ip; ifu_req_addr = ip ? i_addr : $urandom;
      lsu_req_valid = lp; lsu_req_wr = lp ? l_wr : $urandom_range(0, 1);
      lsu_req_addr = lp ? l_addr : $urandom; lsu_req_wdata = lp ? l_wdata : $urandom;
      lsu_req_wstrb = lp ? l_wstrb : $urandom;
      mem_ready = (ph == 1) ? (c >= rdy_at) : $urandom_range(0, 1);
      if (ph == 2) begin
        mem_rsp_valid = (c == rsp_at);
        mem_rdata = (c == rsp_at) ? rd_val : $urandom;
      end else begin
        mem_rsp_valid = $urandom_range(0, 1);
        mem_rdata = $urandom;
      end
      #3;
      e_i = 1'b0; e_l = 1'b0;
      if (ph == 0 && c >= free_at) begin
        if (ip && lp) begin
          e_l = !m_last_lsu; e_i = m_last_lsu;
        end else begin
          e_l = lp; e_i = ip;
        end
      end
      chk("rnd_ifu_rdy", ifu_req_ready, e_i);
      chk("rnd_lsu_rdy", lsu_req_ready, e_l);
      if (ph == 2 && c == exp_at) begin
        chk("rnd_rsp_vld", {ifu_rsp_valid, lsu_rsp_valid}, t_lsu ? 2'b01 : 2'b10);
        chk("rnd_rsp_err", t_lsu ? lsu_rsp_err : ifu_rsp_err, exp_err);
        if (!(t_lsu && t_wr)) chk("rnd_rsp_data", t_lsu ? lsu_rsp_data : ifu_rsp_data, exp_data);
        ph = 0;
      end else begin
        chk("rnd_no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
      end
      if (ph == 1) begin
        chk("rnd_mem_en", mem_en, 1'b1);
        chk("rnd_mem_addr", mem_addr, t_addr);
        chk("rnd_mem_wr", {mem_wr, mem_wstrb}, {t_wr, t_wstrb});
        if (t_wr) chk("rnd_mem_wdata", mem_wdata, t_wdata);
        if (mem_ready) begin
          acc = c; ph = 2;
          if ($urandom_range(0, 9) < 8) begin
            rsp_at = acc + $urandom_range(1, TO + 1);
            exp_at = rsp_at + 1; exp_err = 1'b0;
            rd_val = $urandom; exp_data = rd_val;
          end else begin
            rsp_at = -1; exp_at = acc + TO + 1; exp_err = 1'b1; exp_data = 32'h0;
          end
          free_at = exp_at + 1;
        end
      end else begin
        chk("rnd_mem_idle", mem_en, 1'b0);
      end
      if (e_i || e_l) begin
        t_lsu = e_l; t_wr = e_l && l_wr;
        t_addr = e_l ? l_addr : i_addr; t_wdata = l_wdata;
        t_wstrb = (e_l && l_wr) ? l_wstrb : 4'h0;
        m_last_lsu = e_l;
        if (e_l) lp = 1'b0; else ip = 1'b0;
        ph = 1; rdy_at = c + 1 + $urandom_range(0, 3); free_at = 1 << 30;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
